sbox_feeder_masked: RTL

- Upstream stage for the masked S-box control datapath (first-order, two shares).
- Accepts masked bytes over a valid/ready stream and presents each byte as value_in shares with a start code and load control.
- Counts Synch pulses from the clock-gating controller and captures value_out shares once the configured number of S-box passes completes.
- Supplies per-cycle Fresh randomness from an internal LFSR and returns results on an output valid/ready stream.

---
 rtl/sbox_feeder_masked.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sbox_feeder_masked.sv
// Stream front-end for the first-order two-share masked S-box datapath.
// Presents input shares, counts Synch pulses, captures the result and supplies Fresh randomness.
module sbox_feeder_masked #(
    parameter int unsigned ROUNDS    = 4,
    parameter logic [3:0]  START_VAL = 4'h0,
    parameter logic [31:0] LFSR_SEED = 32'h1ACE_B00C,
    parameter int unsigned FRESH_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_s0,
    input  logic [7:0]         in_s1,
    output logic [7:0]         value_in_s0,
    output logic [7:0]         value_in_s1,
    output logic [3:0]         start,
    output logic               load,
    input  logic               Synch,
    input  logic [7:0]         value_out_s0,
    input  logic [7:0]         value_out_s1,
    output logic [FRESH_W-1:0] Fresh,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_s0,
    output logic [7:0]         out_s1
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0] LFSR_INIT = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [3:0]  ROUNDS_C  = 4'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        HOLD
    } state_t;

    state_t      state_q;
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [3:0]  sync_cnt_q;
    logic [3:0]  sync_cnt_d;
    logic        in_ready_q;
    logic        load_q;
    logic        out_valid_q;
    logic [3:0]  start_q;
    logic [7:0]  value_in_s0_q;
    logic [7:0]  value_in_s1_q;
    logic [7:0]  out_s0_q;
    logic [7:0]  out_s1_q;

    // Fibonacci feedback for x^32 + x^22 + x^2 + x + 1.
    always_comb begin
        lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    assign sync_cnt_d = sync_cnt_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_INIT;
            sync_cnt_q    <= 4'd0;
            in_ready_q    <= 1'b0;
            load_q        <= 1'b1;
            out_valid_q   <= 1'b0;
            start_q       <= START_VAL;
            value_in_s0_q <= 8'h00;
            value_in_s1_q <= 8'h00;
            out_s0_q      <= 8'h00;
            out_s1_q      <= 8'h00;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        value_in_s0_q <= in_s0;
                        value_in_s1_q <= in_s1;
                        in_ready_q    <= 1'b0;
                        state_q       <= LOAD;
                    end
                end
                LOAD: begin
                    start_q    <= START_VAL;
                    load_q     <= 1'b0;
                    sync_cnt_q <= 4'd0;
                    state_q    <= RUN;
                end
                RUN: begin
                    // Capture on the very edge of the final pulse so out_valid rises the next cycle.
                    if (Synch) begin
                        sync_cnt_q <= sync_cnt_d;
                        if (sync_cnt_d == ROUNDS_C) begin
                            out_s0_q    <= value_out_s0;
                            out_s1_q    <= value_out_s1;
                            out_valid_q <= 1'b1;
                            state_q     <= CAPTURE;
                        end
                    end
                end
                CAPTURE, HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        load_q      <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign load        = load_q;
    assign start       = start_q;
    assign out_valid   = out_valid_q;
    assign value_in_s0 = value_in_s0_q;
    assign value_in_s1 = value_in_s1_q;
    assign out_s0      = out_s0_q;
    assign out_s1      = out_s1_q;
    assign Fresh       = lfsr_q[FRESH_W-1:0];

endmodule
